// File: rtl/l1_rd_rsp_if.sv
// l1_rd_rsp_if: read-port request, BRAM and AFU response signals of one L1 read responder
interface l1_rd_rsp_if #(
  parameter int nstrms_width = 6,
  parameter int ptr_width = 1,
  parameter int data_width = 64
);
  logic i_addr_v;
  logic i_addr_r;
  logic [ptr_width-1:0] i_addr_ptr;
  logic [nstrms_width-1:0] i_addr_sid;
  logic o_bram_re;
  logic [nstrms_width+ptr_width-1:0] o_bram_addr;
  logic [data_width-1:0] i_bram_data;
  logic o_rd_v;
  logic o_rd_r;
  logic [data_width-1:0] o_rd_data;
  logic [nstrms_width-1:0] o_rd_sid;
  logic o_idle;
  modport slave (
    input i_addr_v, i_addr_ptr, i_addr_sid, i_bram_data, o_rd_r,
    output i_addr_r, o_bram_re, o_bram_addr, o_rd_v, o_rd_data, o_rd_sid, o_idle
  );
  modport master (
    output i_addr_v, i_addr_ptr, i_addr_sid, i_bram_data, o_rd_r,
    input i_addr_r, o_bram_re, o_bram_addr, o_rd_v, o_rd_data, o_rd_sid, o_idle
  );
endinterface

// File: rtl/l1_rd_rsp.sv
// l1_rd_rsp: issues L1 read requests to BRAM and returns latency-aligned data through a credit-limited FIFO
module l1_rd_rsp #(
  parameter int nstrms = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int ptr_width = 1,
  parameter int data_width = 64,
  parameter int bram_lat = 2,
  parameter int fifo_depth = 4,
  parameter int cnt_width = $clog2(fifo_depth + 1)
) (
  input logic clk,
  input logic reset,
  l1_rd_rsp_if.slave bus
);
  localparam int aw = fifo_depth > 1 ? $clog2(fifo_depth) : 1;
  localparam int ew = nstrms_width + data_width;
  logic [bram_lat-1:0] pipe_v;
  logic [bram_lat-1:0][nstrms_width-1:0] pipe_sid;
  logic [ew-1:0] mem [fifo_depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [cnt_width-1:0] fifo_cnt;
  logic [cnt_width:0] inflight;
  logic acc, push, pop;
  function automatic logic [aw-1:0] nxt(input logic [aw-1:0] p);
    return p == aw'(fifo_depth - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    inflight = '0;
    for (int i = 0; i < bram_lat; i++) inflight = inflight + (cnt_width + 1)'(pipe_v[i]);
  end
  // every read in the pipe already owns a FIFO slot, so returns can never be dropped
  assign bus.i_addr_r = ({1'b0, fifo_cnt} + inflight) < (cnt_width + 1)'(fifo_depth);
  assign acc = bus.i_addr_v & bus.i_addr_r;
  assign bus.o_bram_re = acc;
  assign bus.o_bram_addr = acc ? {bus.i_addr_sid, bus.i_addr_ptr} : '0;
  assign push = pipe_v[bram_lat-1];
  assign pop = bus.o_rd_v & bus.o_rd_r;
  assign bus.o_rd_v = fifo_cnt != '0;
  assign {bus.o_rd_sid, bus.o_rd_data} = mem[rd_ptr];
  assign bus.o_idle = ~|pipe_v & (fifo_cnt == '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pipe_v <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
    end else begin
      pipe_v <= bram_lat'({pipe_v, acc});
      wr_ptr <= push ? nxt(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
      fifo_cnt <= fifo_cnt + cnt_width'(push) - cnt_width'(pop);
    end
  always_ff @(posedge clk) begin
    pipe_sid <= (bram_lat * nstrms_width)'({pipe_sid, bus.i_addr_sid});
    if (push) mem[wr_ptr] <= {pipe_sid[bram_lat-1], bus.i_bram_data};
  end
  assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && fifo_cnt == cnt_width'(fifo_depth)));
endmodule

// File: tb/tb_l1_rd_rsp.sv
// tb_l1_rd_rsp: random and directed checks of l1_rd_rsp against an outstanding-request queue model
module tb_l1_rd_rsp;
  localparam int LAT = 2;
  localparam int DEPTH = 4;
  typedef struct {
    logic [5:0] sid;
    logic [63:0] data;
  } rsp_t;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_pop = 0;
  int outstanding = 0;
  logic rv_seen;
  rsp_t q[$];
  logic [63:0] mem [128];
  logic [6:0] ba [LAT];
  logic bv [LAT];
  logic [63:0] junk;

  l1_rd_rsp_if #(.nstrms_width(6), .ptr_width(1), .data_width(64)) bus();
  l1_rd_rsp #(.nstrms(64), .ptr_width(1), .data_width(64), .bram_lat(LAT), .fifo_depth(DEPTH))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // BRAM: fixed latency, garbage on the bus whenever no read is returning
  always @(posedge clk) begin
    ba[0] <= bus.o_bram_addr;
    bv[0] <= bus.o_bram_re;
    for (int i = 1; i < LAT; i++) begin
      ba[i] <= ba[i-1];
      bv[i] <= bv[i-1];
    end
    junk <= {$urandom, $urandom};
  end
  assign bus.i_bram_data = bv[LAT-1] ? mem[ba[LAT-1]] : junk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [5:0] s, input logic p, input logic r);
    logic acc;
    @(negedge clk);
    rv_seen = bus.o_rd_v;
    check("addr_r", 64'(bus.i_addr_r), 64'(outstanding < DEPTH));
    check("idle", 64'(bus.o_idle), 64'(outstanding == 0));
    if (outstanding == 0) check("rd_v_empty", 64'(bus.o_rd_v), 64'd0);
    acc = v && (outstanding < DEPTH);
    bus.i_addr_v = v;
    bus.i_addr_sid = s;
    bus.i_addr_ptr = p;
    bus.o_rd_r = r;
    #1;
    check("bram_re", 64'(bus.o_bram_re), 64'(acc));
    check("bram_addr", 64'(bus.o_bram_addr), acc ? 64'({s, p}) : 64'd0);
    if (bus.o_rd_v && r) begin
      if (q.size() == 0) check("spurious", 64'(bus.o_rd_v), 64'd0);
      else begin
        check("rd_sid", 64'(bus.o_rd_sid), 64'(q[0].sid));
        check("rd_data", bus.o_rd_data, q[0].data);
        void'(q.pop_front());
        outstanding--;
        n_pop++;
      end
    end
    if (acc) begin
      q.push_back('{s, mem[{s, p}]});
      outstanding++;
      n_acc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.i_addr_v = 0;
    reset = 0;
    #1;
    check("rst_addr_r", 64'(bus.i_addr_r), 64'd1);
    check("rst_bram_re", 64'(bus.o_bram_re), 64'd0);
    check("rst_bram_addr", 64'(bus.o_bram_addr), 64'd0);
    check("rst_rd_v", 64'(bus.o_rd_v), 64'd0);
    check("rst_idle", 64'(bus.o_idle), 64'd1);
    q.delete();
    outstanding = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && outstanding > 0; i++) step(0, 0, 0, 1);
    check(tag, 64'(outstanding), 64'd0);
  endtask

  initial begin
    int a0, p0, cyc;
    for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom};
    bus.i_addr_v = 0;
    bus.i_addr_sid = 0;
    bus.i_addr_ptr = 0;
    bus.o_rd_r = 0;
    do_reset();
    // single read: response visible three cycles after the accept
    step(1, 6'd5, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check("lat_rd_v", 64'(rv_seen), 64'(i == 2));
    end
    step(0, 0, 0, 1);
    check("single_idle", 64'(bus.o_idle), 64'd1);
    // streaming at full rate
    a0 = n_acc;
    p0 = n_pop;
    for (int i = 0; i < 32; i++) step(1, 6'(i), 1'(i), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("stream_acc", 64'(n_acc - a0), 64'd32);
    check("stream_pop", 64'(n_pop - p0), 64'd32);
    // back-pressure fills exactly the credit, then push/pop at full
    a0 = n_acc;
    for (int i = 0; i < 10; i++) step(1, 6'($urandom), 1'($urandom), 0);
    check("bp_acc", 64'(n_acc - a0), 64'(DEPTH));
    check("bp_addr_r", 64'(bus.i_addr_r), 64'd0);
    for (int i = 0; i < 20; i++) step(1, 6'($urandom), 1'($urandom), 1);
    drain("bp_drain");
    // reset with responses queued and in flight
    step(1, 6'd1, 0, 0);
    step(1, 6'd2, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 6'd3, 0, 0);
    step(1, 6'd4, 1, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      check("post_rst_rd_v", 64'(rv_seen), 64'd0);
    end
    // random traffic
    a0 = n_acc;
    cyc = 0;
    while (n_acc - a0 < 10000 && cyc < 60000) begin
      step(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      cyc++;
    end
    check("rand_acc", 64'(n_acc - a0), 64'd10000);
    drain("rand_drain");
    step(0, 0, 0, 1);
    check("final_idle", 64'(bus.o_idle), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
